imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter DEPTH, default 1024, instruction memory capacity in 16-bit words.
REQ-002 Parameter HALT_WORD, default 16'hFFFF, end-of-program marker.
REQ-003 clock  input  1  single clock; all state updates on rising edge.
REQ-004 reset_n  input  1  reset is synchronous and active-low.
REQ-005 start  input  1  begin a new program load.
REQ-006 in_valid  input  1  byte stream valid.
REQ-007 in_data  input  8  program byte, high byte of each word first.
REQ-008 in_ready  output  1  loader accepts a byte this cycle.
REQ-009 mem_we  output  1  instruction memory write strobe.
REQ-010 mem_addr  output  16  byte address of the written word, always even.
REQ-011 mem_wdata  output  16  instruction word to write.
REQ-012 word_count  output  16  words written in the current load, HALT_WORD included.
REQ-013 cpu_run  output  1  program complete; CPU may fetch from PC 0.
REQ-014 error  output  1  program overflowed DEPTH without HALT_WORD.

Function
REQ-015 States: IDLE, HI, LO, WRITE, DONE, ERR.
REQ-016 A byte transfers only on a cycle with in_valid=1 and in_ready=1.
REQ-017 in_ready=1 only in HI and LO; it is 0 in every other state.
REQ-018 The source holds in_data stable while in_valid=1 and in_ready=0.
REQ-019 IDLE: on start=1, clear word_count and the word index, then go to HI.
REQ-020 HI: on a transfer, latch in_data as word[15:8], then go to LO.
REQ-021 LO: on a transfer, latch in_data as word[7:0], then go to WRITE.
REQ-022 WRITE lasts exactly one cycle with mem_we=1, mem_addr=index*2 and mem_wdata=the assembled word; word_count increments by 1.
REQ-023 WRITE exit, in this priority:
  - word==HALT_WORD: go to DONE (the halt word is written).
  - index==DEPTH-1: go to ERR.
  - otherwise: increment index, go to HI.
REQ-024 Minimum throughput is 3 cycles per word; back-to-back valid bytes incur no stall other than WRITE.
REQ-025 DONE: cpu_run=1 from the cycle after the final WRITE.
REQ-026 DONE: on start=1, go to HI with index and word_count cleared; cpu_run=0 from the next cycle.
REQ-027 ERR: error=1 and cpu_run=0; on start=1, behave as the start in DONE and clear error.
REQ-028 start is ignored in HI, LO and WRITE.
REQ-029 mem_addr and mem_wdata are don't-care when mem_we=0; mem_we is never 1 outside WRITE.
REQ-030 An odd trailing byte before HALT_WORD is never written; the loader waits in LO.

Reset
REQ-031 While reset_n=0 at a rising edge:
  - go to IDLE;
  - clear index, the word register and word_count;
  - drive mem_we=0, cpu_run=0, error=0 and in_ready=0.
REQ-032 Reset during a load discards any partial word. Memory already written is left intact. The next load restarts at address 0.

Structure
REQ-033 A shared package holds:
  - the state enumeration;
  - HALT_WORD default 16'hFFFF;
  - DEPTH default 1024;
  - the 16-bit word and address width constants.
REQ-034 No sub-module is required; a single FSM with its index counter and word register is the natural partition.

Verification
REQ-035 Basic load:
  - Stimulus: reset, start, then bytes 70 0F 72 07 FF FF.
  - Response: writes (0,700F), (2,7207), (4,FFFF); word_count=3; cpu_run=1 the cycle after the third write.
REQ-036 Irregular source:
  - Stimulus: in_valid toggling randomly, with the byte held across WRITE cycles.
  - Response: the same three writes in order, with no byte dropped or duplicated.
REQ-037 Overflow:
  - Stimulus: DEPTH=4, four words 0001..0004 with no halt word.
  - Response: writes at addresses 0, 2, 4, 6, then error=1, cpu_run=0 and in_ready=0.
REQ-038 Halt in the last slot:
  - Stimulus: DEPTH=4, words 0001 0002 0003 FFFF.
  - Response: DONE with cpu_run=1, error=0 and word_count=4.
REQ-039 Reset mid-word:
  - Stimulus: reset_n=0 after byte 70 is accepted.
  - Response: no write occurs; word_count=0; the next load writes address 0 first.
REQ-040 Restart from DONE:
  - Stimulus: start=1 while in DONE.
  - Response: cpu_run=0 the next cycle; the next write goes to address 0 with word_count=1.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared types and constants for the instruction memory loader
package imem_loader_pkg;

  localparam int WORD_W = 16;
  localparam int ADDR_W = 16;
  localparam int DEPTH_DEFAULT = 1024;
  localparam logic [WORD_W-1:0] HALT_WORD_DEFAULT = 16'hFFFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HI,
    ST_LO,
    ST_WRITE,
    ST_DONE,
    ST_ERR
  } state_t;

endpackage

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - assembles a byte stream into 16-bit words and writes them to instruction memory
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int                DEPTH     = DEPTH_DEFAULT,
  parameter logic [WORD_W-1:0] HALT_WORD = HALT_WORD_DEFAULT
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic [WORD_W-1:0] word_count,
  output logic              cpu_run,
  output logic              error
);

  // The word index addresses words; the byte address is index*2, so one bit fewer suffices.
  localparam int IDX_W = ADDR_W - 1;
  localparam logic [IDX_W-1:0] LAST_INDEX = IDX_W'(DEPTH - 1);

  state_t            state;
  state_t            state_nxt;
  logic [IDX_W-1:0]  index;
  logic [WORD_W-1:0] word;
  logic              xfer;
  logic              restart;
  logic              is_halt;
  logic              is_last;

  assign xfer    = in_valid && in_ready;
  assign restart = start && (state == ST_IDLE || state == ST_DONE || state == ST_ERR);
  assign is_halt = (word == HALT_WORD);
  assign is_last = (index == LAST_INDEX);

  // State register.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; WRITE always leaves after one cycle, halt word takes priority over overflow.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start) state_nxt = ST_HI;
      ST_HI:    if (xfer) state_nxt = ST_LO;
      ST_LO:    if (xfer) state_nxt = ST_WRITE;
      ST_WRITE: begin
        if (is_halt) begin
          state_nxt = ST_DONE;
        end else if (is_last) begin
          state_nxt = ST_ERR;
        end else begin
          state_nxt = ST_HI;
        end
      end
      ST_DONE:  if (start) state_nxt = ST_HI;
      ST_ERR:   if (start) state_nxt = ST_HI;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Word assembly, index and word count; a reset drops any half-assembled word.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      index      <= '0;
      word       <= '0;
      word_count <= '0;
    end else begin
      if (restart) begin
        index      <= '0;
        word_count <= '0;
      end
      if (state == ST_HI && xfer) begin
        word[15:8] <= in_data;
      end
      if (state == ST_LO && xfer) begin
        word[7:0] <= in_data;
      end
      if (state == ST_WRITE) begin
        word_count <= word_count + 16'd1;
        if (!is_halt && !is_last) begin
          index <= index + 1'b1;
        end
      end
    end
  end

  // Outputs decoded from the current state only.
  always_comb begin
    in_ready  = (state == ST_HI) || (state == ST_LO);
    mem_we    = (state == ST_WRITE);
    mem_addr  = {index, 1'b0};
    mem_wdata = word;
    cpu_run   = (state == ST_DONE);
    error     = (state == ST_ERR);
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - randomized self-checking bench for imem_loader
module tb_imem_loader;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        start_a;
  logic        start_b;
  logic        in_valid;
  logic [7:0]  in_data;

  logic        in_ready_a, mem_we_a, cpu_run_a, error_a;
  logic [15:0] mem_addr_a, mem_wdata_a, word_count_a;
  logic        in_ready_b, mem_we_b, cpu_run_b, error_b;
  logic [15:0] mem_addr_b, mem_wdata_b, word_count_b;

  always #5 clock = ~clock;

  imem_loader dut_a (
    .clock(clock), .reset_n(reset_n), .start(start_a),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready_a),
    .mem_we(mem_we_a), .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a),
    .word_count(word_count_a), .cpu_run(cpu_run_a), .error(error_a)
  );

  imem_loader #(.DEPTH(4)) dut_b (
    .clock(clock), .reset_n(reset_n), .start(start_b),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready_b),
    .mem_we(mem_we_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b),
    .word_count(word_count_b), .cpu_run(cpu_run_b), .error(error_b)
  );

  int checks = 0;
  int errors = 0;
  int cycle  = 0;
  bit sel    = 1'b0;

  logic [47:0] wq_a[$];
  logic [47:0] wq_b[$];
  logic [15:0] prog_q[$];
  logic [15:0] exp_q[$];

  logic        s_rdy, s_run, s_err;
  logic [15:0] s_cnt;
  assign s_rdy = sel ? in_ready_b   : in_ready_a;
  assign s_run = sel ? cpu_run_b    : cpu_run_a;
  assign s_err = sel ? error_b      : error_a;
  assign s_cnt = sel ? word_count_b : word_count_a;

  always @(posedge clock) cycle <= cycle + 1;

  always @(negedge clock) begin
    if (mem_we_a) wq_a.push_back({cycle[15:0], mem_addr_a, mem_wdata_a});
    if (mem_we_b) wq_b.push_back({cycle[15:0], mem_addr_b, mem_wdata_b});
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset_n  = 1'b0;
    start_a  = 1'b0;
    start_b  = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    tick();
    tick();
    reset_n = 1'b1;
    wq_a.delete();
    wq_b.delete();
  endtask

  task automatic pulse_start(input bit s);
    if (s) start_b = 1'b1;
    else   start_a = 1'b1;
    tick();
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  // Offers one byte until the selected loader takes it; irregular mode toggles in_valid randomly.
  task automatic send_byte(input logic [7:0] b, input bit irregular);
    bit ok = 1'b0;
    in_data = b;
    for (int t = 0; t < 60 && !ok; t++) begin
      in_valid = irregular ? ($urandom_range(0, 2) != 0) : 1'b1;
      @(negedge clock);
      if (s_rdy && in_valid) ok = 1'b1;
      tick();
    end
    if (!ok) chk("send_timeout", 32'(ok), 32'd1);
  endtask

  // Reference: words are written in order until the halt word or until the memory is full.
  task automatic model(input int depth, output int outcome);
    exp_q.delete();
    outcome = 0;
    for (int k = 0; k < prog_q.size() && outcome == 0; k++) begin
      exp_q.push_back(prog_q[k]);
      if (prog_q[k] == 16'hFFFF) outcome = 1;
      else if (k == depth - 1)   outcome = 2;
    end
  endtask

  task automatic send_prog(input bit irregular);
    logic [15:0] w;
    for (int k = 0; k < exp_q.size(); k++) begin
      w = exp_q[k];
      send_byte(w[15:8], irregular);
      send_byte(w[7:0], irregular);
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_end();
    bit seen = 1'b0;
    for (int t = 0; t < 20 && !seen; t++) begin
      @(negedge clock);
      if (s_run || s_err) seen = 1'b1;
    end
    if (!seen) chk("end_timeout", 32'(seen), 32'd1);
  endtask

  task automatic check_writes(input bit s, input string tag);
    logic [47:0] e;
    int n;
    n = s ? wq_b.size() : wq_a.size();
    chk({tag, "_nwrites"}, 32'(n), 32'(exp_q.size()));
    for (int k = 0; k < n && k < exp_q.size(); k++) begin
      e = s ? wq_b[k] : wq_a[k];
      chk({tag, "_addr"}, 32'(e[31:16]), 32'(2 * k));
      chk({tag, "_data"}, 32'(e[15:0]), 32'(exp_q[k]));
    end
  endtask

  task automatic run_random(input bit s, input int depth, input bit irregular);
    int n;
    int outcome;
    bit odd;
    n = $urandom_range(1, 6);
    prog_q.delete();
    for (int k = 0; k < n; k++) begin
      logic [15:0] w;
      w = 16'($urandom);
      if (w == 16'hFFFF) w = 16'h0000;
      prog_q.push_back(w);
    end
    if ($urandom_range(0, 2) != 0) prog_q[n-1] = 16'hFFFF;
    odd = $urandom_range(0, 1) != 0;
    model(depth, outcome);
    do_reset();
    sel = s;
    pulse_start(s);
    send_prog(irregular);
    if (outcome == 0) begin
      if (odd) send_byte(8'($urandom), irregular);
      in_valid = 1'b0;
      repeat (5) tick();
      chk("rnd_wait_run", 32'(s_run), 32'd0);
      chk("rnd_wait_err", 32'(s_err), 32'd0);
      chk("rnd_wait_rdy", 32'(s_rdy), 32'd1);
    end else begin
      wait_end();
      repeat (2) tick();
      chk("rnd_run", 32'(s_run), 32'(outcome == 1));
      chk("rnd_err", 32'(s_err), 32'(outcome == 2));
      chk("rnd_rdy", 32'(s_rdy), 32'd0);
    end
    chk("rnd_count", 32'(s_cnt), 32'(exp_q.size()));
    check_writes(s, "rnd");
  endtask

  initial begin
    int outcome;
    logic [47:0] e0, e1;

    // Reset state
    do_reset();
    sel = 1'b0;
    @(negedge clock);
    chk("rst_ready", 32'(in_ready_a), 32'd0);
    chk("rst_we", 32'(mem_we_a), 32'd0);
    chk("rst_run", 32'(cpu_run_a), 32'd0);
    chk("rst_err", 32'(error_a), 32'd0);
    chk("rst_count", 32'(word_count_a), 32'd0);
    tick();

    // Basic load, back-to-back bytes
    prog_q = '{16'h700F, 16'h7207, 16'hFFFF};
    model(1024, outcome);
    pulse_start(1'b0);
    send_prog(1'b0);
    @(negedge clock);
    chk("basic_last_we", 32'(mem_we_a), 32'd1);
    chk("basic_run_at_write", 32'(cpu_run_a), 32'd0);
    @(negedge clock);
    chk("basic_run_after", 32'(cpu_run_a), 32'd1);
    chk("basic_count", 32'(word_count_a), 32'd3);
    chk("basic_err", 32'(error_a), 32'd0);
    check_writes(1'b0, "basic");
    if (wq_a.size() >= 2) begin
      e0 = wq_a[0];
      e1 = wq_a[1];
      chk("basic_rate", 32'(e1[47:32] - e0[47:32]), 32'd3);
    end
    tick();

    // Restart from DONE, then irregular source
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    chk("restart_run", 32'(cpu_run_a), 32'd0);
    chk("restart_rdy", 32'(in_ready_a), 32'd1);
    chk("restart_count", 32'(word_count_a), 32'd0);
    wq_a.delete();
    send_byte(8'h70, 1'b1);
    send_byte(8'h0F, 1'b1);
    in_valid = 1'b0;
    @(negedge clock);
    chk("restart_we", 32'(mem_we_a), 32'd1);
    chk("restart_addr", 32'(mem_addr_a), 32'd0);
    @(negedge clock);
    chk("restart_count1", 32'(word_count_a), 32'd1);
    tick();
    prog_q = '{16'h7207, 16'hFFFF};
    model(1024, outcome);
    send_prog(1'b1);
    wait_end();
    chk("irr_count", 32'(word_count_a), 32'd3);
    prog_q = '{16'h700F, 16'h7207, 16'hFFFF};
    model(1024, outcome);
    check_writes(1'b0, "irr");

    // Reset in the middle of a word
    do_reset();
    pulse_start(1'b0);
    send_byte(8'h70, 1'b0);
    in_valid = 1'b0;
    reset_n  = 1'b0;
    tick();
    reset_n = 1'b1;
    repeat (3) tick();
    chk("midrst_writes", 32'(wq_a.size()), 32'd0);
    chk("midrst_count", 32'(word_count_a), 32'd0);
    chk("midrst_rdy", 32'(in_ready_a), 32'd0);
    prog_q = '{16'h1234, 16'hFFFF};
    model(1024, outcome);
    pulse_start(1'b0);
    send_prog(1'b0);
    wait_end();
    check_writes(1'b0, "midrst");

    // Overflow on the small instance
    do_reset();
    sel = 1'b1;
    prog_q = '{16'h0001, 16'h0002, 16'h0003, 16'h0004};
    model(4, outcome);
    pulse_start(1'b1);
    send_prog(1'b0);
    wait_end();
    chk("ovf_err", 32'(error_b), 32'd1);
    chk("ovf_run", 32'(cpu_run_b), 32'd0);
    chk("ovf_rdy", 32'(in_ready_b), 32'd0);
    chk("ovf_count", 32'(word_count_b), 32'd4);
    check_writes(1'b1, "ovf");
    tick();

    // Restart from ERR, halt in the last slot
    pulse_start(1'b1);
    chk("errst_err", 32'(error_b), 32'd0);
    chk("errst_rdy", 32'(in_ready_b), 32'd1);
    wq_b.delete();
    prog_q = '{16'h0001, 16'h0002, 16'h0003, 16'hFFFF};
    model(4, outcome);
    send_prog(1'b1);
    wait_end();
    chk("lastslot_run", 32'(cpu_run_b), 32'd1);
    chk("lastslot_err", 32'(error_b), 32'd0);
    chk("lastslot_count", 32'(word_count_b), 32'd4);
    check_writes(1'b1, "lastslot");

    // Randomized programs on both depths
    for (int i = 0; i < 24; i++) begin
      run_random(i[0], i[0] ? 4 : 1024, i[1]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
